// File: rtl/mem_interconnect.sv
// Round-robin interconnect letting NUM_MASTERS requesters share BRAM port A and an MMIO register bank.
// Reads return a fixed READ_LATENCY cycles after grant regardless of the decoded region.
module mem_interconnect #(
  parameter int unsigned       NUM_MASTERS  = 32'd2,
  parameter int unsigned       ADDR_W       = 32'd16,
  parameter int unsigned       DATA_W       = 32'd16,
  parameter logic [ADDR_W-1:0] RAM_LIMIT    = 16'h4000,
  parameter int unsigned       MMIO_REGS    = 32'd4,
  parameter int unsigned       READ_LATENCY = 32'd1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [ADDR_W-1:0]             bram_addra,
  output logic [DATA_W-1:0]             bram_dina,
  output logic                          bram_wea,
  input  logic [DATA_W-1:0]             bram_douta,
  output logic [MMIO_REGS*DATA_W-1:0]   mmio_out,
  output logic [MMIO_REGS-1:0]          mmio_we,
  output logic                          bus_err
);

  localparam int unsigned ID_W    = (NUM_MASTERS > 32'd1) ? $clog2(NUM_MASTERS) : 32'd1;
  localparam int unsigned MI_W    = (MMIO_REGS > 32'd1) ? $clog2(MMIO_REGS) : 32'd1;
  localparam logic [ID_W:0] NUM_M_W = (ID_W+1)'(NUM_MASTERS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_MASTERS - 32'd1);

  typedef enum logic [1:0] {
    REG_BRAM  = 2'd0,
    REG_MMIO  = 2'd1,
    REG_UNMAP = 2'd2
  } region_e;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic              is_bram;
    logic [DATA_W-1:0] data;
  } rd_stage_t;

  logic [ID_W-1:0]   p_r;
  logic [ID_W-1:0]   win_id_s;
  logic [ID_W-1:0]   p_next_s;
  logic [ID_W:0]     cand_s;
  logic              win_found_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic [ADDR_W-1:0] mmio_off_s;
  logic [MI_W-1:0]   mmio_idx_s;
  region_e           region_s;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] din_hold_r;
  logic [DATA_W-1:0] mmio_r [MMIO_REGS];
  logic [MMIO_REGS-1:0] mmio_we_r;
  logic              bus_err_r;
  rd_stage_t         pipe_r [READ_LATENCY];
  rd_stage_t         rd_in_s;
  rd_stage_t         rd_out_s;

  // Round-robin search: first requester at or after the pointer, wrapping once
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand_s = {1'b0, p_r} + (ID_W+1)'(k);
      if (cand_s >= NUM_M_W) begin
        cand_s = cand_s - NUM_M_W;
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && m_req[cand_s[ID_W-1:0]]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s[ID_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Winner's request fields, one-hot grant and next pointer value
  always_comb begin
    win_addr_s  = m_addr[win_id_s*ADDR_W +: ADDR_W];
    win_wdata_s = m_wdata[win_id_s*DATA_W +: DATA_W];
    win_we_s    = m_we[win_id_s];
    m_gnt       = '0;
    if (win_found_s) begin
      m_gnt[win_id_s] = 1'b1;
    end else begin
      m_gnt = '0;
    end
    if (win_id_s == LAST_ID) begin
      p_next_s = '0;
    end else begin
      p_next_s = win_id_s + ID_W'(32'd1);
    end
  end

  // Address decode of the granted request
  always_comb begin
    mmio_off_s = win_addr_s - RAM_LIMIT;
    mmio_idx_s = mmio_off_s[MI_W-1:0];
    if (win_addr_s < RAM_LIMIT) begin
      region_s = REG_BRAM;
    end else if (mmio_off_s < ADDR_W'(MMIO_REGS)) begin
      region_s = REG_MMIO;
    end else begin
      region_s = REG_UNMAP;
    end
  end

  // BRAM port A: live from the winner, otherwise the last accepted address/data
  always_comb begin
    if (win_found_s) begin
      bram_addra = win_addr_s;
      bram_dina  = win_wdata_s;
    end else begin
      bram_addra = addr_hold_r;
      bram_dina  = din_hold_r;
    end
    bram_wea = win_found_s & win_we_s & (region_s == REG_BRAM);
  end

  // Read-pipeline entry; MMIO data is captured now so every region sees the same latency
  always_comb begin
    rd_in_s.valid   = win_found_s & ~win_we_s;
    rd_in_s.id      = win_id_s;
    rd_in_s.is_bram = 1'b0;
    rd_in_s.data    = '0;
    case (region_s)
      REG_BRAM: rd_in_s.is_bram = 1'b1;
      REG_MMIO: rd_in_s.data    = mmio_r[mmio_idx_s];
      default:  rd_in_s.data    = '0;
    endcase
  end

  // Arbitration pointer and held BRAM address/data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_r         <= '0;
      addr_hold_r <= '0;
      din_hold_r  <= '0;
    end else if (win_found_s) begin
      p_r         <= p_next_s;
      addr_hold_r <= win_addr_s;
      din_hold_r  <= win_wdata_s;
    end
  end

  // MMIO registers, write strobes and the sticky bus error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < MMIO_REGS; k++) begin
        mmio_r[k] <= '0;
      end
      mmio_we_r <= '0;
      bus_err_r <= 1'b0;
    end else begin
      mmio_we_r <= '0;
      if (win_found_s && win_we_s && (region_s == REG_MMIO)) begin
        mmio_r[mmio_idx_s]    <= win_wdata_s;
        mmio_we_r[mmio_idx_s] <= 1'b1;
      end
      if (win_found_s && (region_s == REG_UNMAP)) begin
        bus_err_r <= 1'b1;
      end
    end
  end

  // Read return shift pipeline; reset drops anything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= rd_in_s;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Read return to the owning master
  always_comb begin
    rd_out_s = pipe_r[READ_LATENCY-1];
    m_rvalid = '0;
    if (rd_out_s.valid) begin
      m_rvalid[rd_out_s.id] = 1'b1;
    end else begin
      m_rvalid = '0;
    end
    m_rdata = rd_out_s.is_bram ? bram_douta : rd_out_s.data;
  end

  // Flatten MMIO registers onto the packed output
  always_comb begin
    mmio_out = '0;
    for (int unsigned k = 0; k < MMIO_REGS; k++) begin
      mmio_out[k*DATA_W +: DATA_W] = mmio_r[k];
    end
  end

  assign mmio_we = mmio_we_r;
  assign bus_err = bus_err_r;

endmodule

// File: tb/tb_mem_interconnect.sv
// Bench for mem_interconnect with 4 masters and 3-cycle read latency, a behavioural BRAM,
// a cycle monitor with a reference model/scoreboard, a directed vector table and random traffic.
module tb_mem_interconnect;
  localparam int N  = 4;
  localparam int L  = 3;
  localparam int MR = 4;
  localparam logic [15:0] RAM_LIMIT = 16'h4000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]    m_req = '0;
  logic [N-1:0]    m_we = '0;
  logic [N*16-1:0] m_addr = '0;
  logic [N*16-1:0] m_wdata = '0;
  logic [N-1:0]    m_gnt;
  logic [N-1:0]    m_rvalid;
  logic [15:0]     m_rdata;
  logic [15:0]     bram_addra;
  logic [15:0]     bram_dina;
  logic            bram_wea;
  logic [15:0]     bram_douta;
  logic [MR*16-1:0] mmio_out;
  logic [MR-1:0]   mmio_we;
  logic            bus_err;

  always #5 clk = ~clk;

  mem_interconnect #(.NUM_MASTERS(N), .ADDR_W(16), .DATA_W(16), .RAM_LIMIT(RAM_LIMIT),
                     .MMIO_REGS(MR), .READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_wea(bram_wea), .bram_douta(bram_douta),
    .mmio_out(mmio_out), .mmio_we(mmio_we), .bus_err(bus_err));

  // Behavioural BRAM with L-cycle read latency
  logic [15:0] bram_mem [0:16383];
  logic [15:0] bram_pipe [L];
  initial begin
    for (int i = 0; i < 16384; i++) bram_mem[i] = 16'h0000;
    for (int i = 0; i < L; i++) bram_pipe[i] = 16'h0000;
  end
  always @(posedge clk) begin
    if (bram_wea) bram_mem[bram_addra[13:0]] <= bram_dina;
    bram_pipe[0] <= bram_mem[bram_addra[13:0]];
    for (int i = 1; i < L; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign bram_douta = bram_pipe[L-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int m);
    onehot = '0;
    onehot[m] = 1'b1;
  endfunction

  // Reference model and scoreboard
  typedef struct { int due; int id; logic [15:0] data; } sb_t;
  sb_t sb_q[$];
  logic [15:0] ref_mem [int];
  logic [15:0] mmio_m [MR];
  logic [MR-1:0] we_pend_m = '0;
  logic err_m = 1'b0;
  int cyc_m = 0;
  int ptr_m = 0;
  sb_t e_mon;
  logic [N-1:0] exp_rv_mon, exp_gnt_mon;
  logic [15:0] exp_rd_mon, a_mon, wd_mon, rdv_mon;
  logic w_mon;
  int win_mon, c_mon, ai_mon;

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      ptr_m = 0;
      err_m = 1'b0;
      we_pend_m = '0;
      for (int k = 0; k < MR; k++) mmio_m[k] = 16'h0000;
    end else begin
      cyc_m++;
      exp_rv_mon = '0;
      exp_rd_mon = 16'h0000;
      if (sb_q.size() > 0 && sb_q[0].due == cyc_m) begin
        e_mon = sb_q.pop_front();
        exp_rv_mon[e_mon.id] = 1'b1;
        exp_rd_mon = e_mon.data;
      end
      chk("mon_rvalid", 64'(m_rvalid), 64'(exp_rv_mon));
      if (exp_rv_mon != '0) chk("mon_rdata", 64'(m_rdata), 64'(exp_rd_mon));
      chk("mon_mmio_we", 64'(mmio_we), 64'(we_pend_m));
      chk("mon_mmio_out", mmio_out, {mmio_m[3], mmio_m[2], mmio_m[1], mmio_m[0]});
      chk("mon_bus_err", 64'(bus_err), 64'(err_m));
      win_mon = -1;
      for (int k = 0; k < N; k++) begin
        c_mon = (ptr_m + k) % N;
        if (win_mon < 0 && m_req[c_mon]) win_mon = c_mon;
      end
      exp_gnt_mon = '0;
      if (win_mon >= 0) exp_gnt_mon[win_mon] = 1'b1;
      chk("mon_gnt", 64'(m_gnt), 64'(exp_gnt_mon));
      we_pend_m = '0;
      if (win_mon >= 0) begin
        a_mon  = m_addr[win_mon*16 +: 16];
        w_mon  = m_we[win_mon];
        wd_mon = m_wdata[win_mon*16 +: 16];
        ai_mon = int'(a_mon);
        chk("mon_bram_wea", 64'(bram_wea), 64'(w_mon && (a_mon < RAM_LIMIT)));
        if (ai_mon < 'h4000) begin
          chk("mon_bram_addra", 64'(bram_addra), 64'(a_mon));
          if (w_mon) begin
            chk("mon_bram_dina", 64'(bram_dina), 64'(wd_mon));
            ref_mem[ai_mon] = wd_mon;
          end else begin
            rdv_mon = ref_mem.exists(ai_mon) ? ref_mem[ai_mon] : 16'h0000;
            sb_q.push_back('{cyc_m + L, win_mon, rdv_mon});
          end
        end else if (ai_mon < 'h4000 + MR) begin
          if (w_mon) begin
            mmio_m[ai_mon - 'h4000] = wd_mon;
            we_pend_m[ai_mon - 'h4000] = 1'b1;
          end else begin
            sb_q.push_back('{cyc_m + L, win_mon, mmio_m[ai_mon - 'h4000]});
          end
        end else begin
          err_m = 1'b1;
          if (!w_mon) sb_q.push_back('{cyc_m + L, win_mon, 16'h0000});
        end
        ptr_m = (win_mon + 1) % N;
      end else begin
        chk("mon_bram_wea_idle", 64'(bram_wea), 64'(0));
      end
    end
  end

  task automatic drive_one(input int m, input logic we, input logic [15:0] a, input logic [15:0] d);
    m_req[m] = 1'b1;
    m_we[m] = we;
    m_addr[m*16 +: 16] = a;
    m_wdata[m*16 +: 16] = d;
  endtask

  // Waits a bounded time for master m's read return and checks latency and data
  task automatic wait_read(input string name, input int m, input logic [15:0] exp);
    int got, lat;
    logic [15:0] rd;
    got = 0; lat = 0; rd = 16'h0000;
    for (int k = 1; k <= 8 && got == 0; k++) begin
      @(negedge clk);
      if (m_rvalid[m]) begin got = 1; lat = k; rd = m_rdata; end
    end
    chk({name, "_rvalid_seen"}, 64'(got), 64'(1));
    if (got == 1) begin
      chk({name, "_latency"}, 64'(lat), 64'(L));
      chk({name, "_rdata"}, 64'(rd), 64'(exp));
    end
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 16'($urandom_range(0, 15));
    else if (r == 6) return 16'h3FFF;
    else if (r <= 8) return 16'h4000 + 16'($urandom_range(0, 3));
    else return ($urandom_range(0, 1) == 0) ? 16'h4004 : 16'hFFFF;
  endfunction

  typedef struct {
    int m; logic we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] exp_rdata; logic exp_err;
  } vec_t;
  vec_t vecs [13];

  logic [N-1:0] prev_gnt, gl;

  initial begin
    vecs[0]  = '{0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1]  = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2]  = '{1, 1'b1, 16'h4002, 16'h00FF, 16'h0000, 1'b0};
    vecs[3]  = '{1, 1'b0, 16'h4002, 16'h0000, 16'h00FF, 1'b0};
    vecs[4]  = '{2, 1'b1, 16'h3FFF, 16'h1357, 16'h0000, 1'b0};
    vecs[5]  = '{2, 1'b0, 16'h3FFF, 16'h0000, 16'h1357, 1'b0};
    vecs[6]  = '{3, 1'b1, 16'h4003, 16'h1234, 16'h0000, 1'b0};
    vecs[7]  = '{0, 1'b0, 16'h4003, 16'h0000, 16'h1234, 1'b0};
    vecs[8]  = '{1, 1'b0, 16'h4000, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    vecs[10] = '{0, 1'b1, 16'h4004, 16'h5555, 16'h0000, 1'b1};
    vecs[11] = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1};
    vecs[12] = '{3, 1'b0, 16'h4004, 16'h0000, 16'h0000, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 64'(m_rvalid), 64'(0));
    chk("rst_mmio_out", mmio_out, 64'(0));
    chk("rst_mmio_we", 64'(mmio_we), 64'(0));
    chk("rst_bus_err", 64'(bus_err), 64'(0));
    @(posedge clk); #1 rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive_one(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk("vec_gnt", 64'(m_gnt), 64'(onehot(vecs[i].m)));
      @(posedge clk); #1 m_req = '0;
      if (!vecs[i].we) wait_read("vec", vecs[i].m, vecs[i].exp_rdata);
      else @(negedge clk);
      chk("vec_bus_err", 64'(bus_err), 64'(vecs[i].exp_err));
    end

    // MMIO write followed next cycle by a read of the same register
    @(posedge clk); #1 drive_one(1, 1'b1, 16'h4001, 16'hAAAA);
    @(posedge clk); #1 m_req = '0; drive_one(0, 1'b0, 16'h4001, 16'h0000);
    @(negedge clk);
    chk("mmio_fwd_we_pulse", 64'(mmio_we), 64'(4'b0010));
    @(posedge clk); #1 m_req = '0;
    wait_read("mmio_fwd", 0, 16'hAAAA);

    // Two masters requesting continuously must alternate every cycle
    @(posedge clk); #1;
    drive_one(0, 1'b0, 16'h0010, 16'h0000);
    drive_one(1, 1'b0, 16'h4002, 16'h0000);
    prev_gnt = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("alt_first", 64'(m_gnt == 4'b0001 || m_gnt == 4'b0010), 64'(1));
      else chk("alt_gnt", 64'(m_gnt), 64'(prev_gnt ^ 4'b0011));
      prev_gnt = m_gnt;
      @(posedge clk); #1;
    end
    m_req = '0;
    repeat (L + 2) @(negedge clk);

    // Reset with two reads in flight
    @(posedge clk); #1;
    drive_one(0, 1'b0, 16'h0010, 16'h0000);
    drive_one(1, 1'b0, 16'h4002, 16'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) drive_one(i, 1'b1, 16'h0030, 16'h0F0F);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("inrst_rvalid", 64'(m_rvalid), 64'(0));
      chk("inrst_mmio_out", mmio_out, 64'(0));
      chk("inrst_bus_err", 64'(bus_err), 64'(0));
      chk("inrst_gnt", 64'(m_gnt), 64'(4'b0001));
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("postrst_gnt", 64'(m_gnt), 64'(4'b0001));
    @(posedge clk); #1 m_req = '0;
    for (int i = 0; i < L + 3; i++) begin
      @(negedge clk);
      chk("postrst_no_rvalid", 64'(m_rvalid), 64'(0));
    end

    // Random traffic, requests held until granted
    gl = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!m_req[i] || gl[i]) begin
          if ($urandom_range(0, 9) < 7) begin
            m_req[i] = 1'b1;
            m_we[i] = ($urandom_range(0, 2) == 0);
            m_addr[i*16 +: 16] = rand_addr();
            m_wdata[i*16 +: 16] = 16'($urandom);
          end else begin
            m_req[i] = 1'b0;
          end
        end
      end
      @(negedge clk);
      gl = m_gnt;
    end
    @(posedge clk); #1 m_req = '0;
    repeat (L + 3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_interconnect.md
# mem_interconnect

Parametrised memory interconnect that lets NUM_MASTERS requesters (CPU memory controller, VGA/blitter DMA, debug loader) share the CPU-side port of the native BRAM and a bank of memory-mapped IO registers. It performs round-robin arbitration with a one-cycle grant handshake, decodes addresses into BRAM, MMIO or unmapped regions, and returns read data with a fixed, region-independent latency. It sits between the masters and `blk_mem_gen_0` port A, replacing the point-to-point controller-to-BRAM wiring.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesters (1..8)
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RAM_LIMIT, 16'h4000, addresses below this map to BRAM
- MMIO_REGS, 4, MMIO registers at RAM_LIMIT .. RAM_LIMIT+MMIO_REGS-1
- READ_LATENCY, 1, BRAM read latency in clk cycles (1..3)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- m_req  in  NUM_MASTERS  per-master request; held with addr/we/wdata until granted
- m_we  in  NUM_MASTERS  1 = write, 0 = read
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  NUM_MASTERS*DATA_W  packed write data
- m_gnt  out  NUM_MASTERS  one-hot accept pulse, combinational in acceptance cycle
- m_rvalid  out  NUM_MASTERS  one-hot read-data-valid pulse
- m_rdata  out  DATA_W  shared read data, valid when any m_rvalid bit is high
- bram_addra  out  ADDR_W  BRAM port A address
- bram_dina  out  DATA_W  BRAM port A write data
- bram_wea  out  1  BRAM port A write enable
- bram_douta  in  DATA_W  BRAM port A read data
- mmio_out  out  MMIO_REGS*DATA_W  packed MMIO register contents (LEDs, VGA control)
- mmio_we  out  MMIO_REGS  one-cycle strobe when register k is written
- bus_err  out  1  sticky, set on any access to an unmapped address

## Operation
- Arbitration: round-robin. Pointer p (reset 0). In each cycle the first requesting master at or after p (wrapping) wins; m_gnt[winner]=1 that cycle; p ← winner+1 mod NUM_MASTERS at the edge. No request: no grant, p unchanged. At most one grant per cycle; back-to-back grants to different masters allowed every cycle.
- Decode of granted address a: a < RAM_LIMIT → BRAM; RAM_LIMIT ≤ a < RAM_LIMIT+MMIO_REGS → MMIO reg (a−RAM_LIMIT); otherwise unmapped.
- BRAM access: bram_addra/bram_dina driven combinationally from winner; bram_wea = grant & we & BRAM region. When no grant: bram_wea=0, addr/din hold last value (don't-care).
- MMIO write: register updated at acceptance edge; mmio_we[k] high for the following cycle.
- Unmapped: write dropped, read returns 0; bus_err ← 1 at acceptance edge, cleared only by reset.
- Reads: a READ_LATENCY-deep shift pipeline carries {valid, master id, region, mmio data}. MMIO/unmapped read data is captured at acceptance and delayed so every read returns exactly READ_LATENCY cycles after grant; m_rdata muxes bram_douta or the pipelined value. Writes never produce m_rvalid.
- No forwarding: BRAM read-during-write behaviour is the BRAM's. MMIO read accepted the cycle after a write to the same register returns the new value.
- Reset: mmio_out, mmio_we, m_rvalid, bus_err, p, pipeline valids all 0; in-flight reads discarded, never returned.

## Timing
- Grant: same cycle as m_req (combinational); master drops or changes request at the next edge.
- Read data: m_rvalid[i] and m_rdata valid exactly READ_LATENCY cycles after the grant cycle, for one cycle.
- MMIO write visible on mmio_out one cycle after grant.
- Throughput: one access per cycle sustained across all masters.
- Reset outputs: m_gnt follows m_req combinationally but no state updates while rst=0; all registered outputs 0.

## Test plan
- Single master, NUM_MASTERS=2: master 0 writes 16'hBEEF to 16'h0010, then reads it → gnt same cycle each; m_rvalid[0] with m_rdata=16'hBEEF READ_LATENCY cycles after read grant.
- Both masters request continuously → grants alternate 0,1,0,1; each read returns to correct master in order, no cycle without a grant.
- MMIO: master 1 writes 16'h00FF to RAM_LIMIT+2 → mmio_out reg2=16'h00FF and mmio_we[2] pulse next cycle; bram_wea stays 0; readback returns 16'h00FF at same latency as BRAM read.
- Unmapped: read 16'hFFFF → m_rvalid with m_rdata=0, bus_err=1 and stays 1 across later good accesses until rst low.
- READ_LATENCY=3, NUM_MASTERS=4, random requests vs reference model → every read data/latency/master id matches; no lost or duplicated rvalid.
- Assert rst=0 with two reads in flight → no m_rvalid afterwards, mmio_out=0, bus_err=0, next grant goes to master 0 when all request.
